// File: rtl/apb4_arbiter2.sv
// Two-requester APB4 arbiter: round-robin grant per transfer onto one
// downstream APB4 slave.
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   s_psel_i[1:0]         requester psel, bit n = requester n
//   s_penable_i[1:0]      requester penable (not used for arbitration)
//   s_pwrite_i[1:0]       requester pwrite
//   s_paddr_i[2*AW-1:0]   packed addresses, [AW*n +: AW] = requester n
//   s_pprot_i[5:0]        packed pprot, 3 bits each
//   s_pstrb_i[2*DW/8-1:0] packed pstrb
//   s_pwdata_i[2*DW-1:0]  packed write data
//   s_pready_o[1:0]       completion pulse, granted requester only
//   s_prdata_o[DW-1:0]    read data, valid with s_pready_o
//   s_pslverr_o[1:0]      forwarded pslverr, granted requester only
//   m_*                   downstream APB4 master port
module apb4_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        s_psel_i,
  input  logic [1:0]        s_penable_i,
  input  logic [1:0]        s_pwrite_i,
  input  logic [2*AW-1:0]   s_paddr_i,
  input  logic [5:0]        s_pprot_i,
  input  logic [2*DW/8-1:0] s_pstrb_i,
  input  logic [2*DW-1:0]   s_pwdata_i,
  output logic [1:0]        s_pready_o,
  output logic [DW-1:0]     s_prdata_o,
  output logic [1:0]        s_pslverr_o,
  output logic              m_psel_o,
  output logic              m_penable_o,
  output logic              m_pwrite_o,
  output logic [AW-1:0]     m_paddr_o,
  output logic [2:0]        m_pprot_o,
  output logic [DW/8-1:0]   m_pstrb_o,
  output logic [DW-1:0]     m_pwdata_o,
  input  logic              m_pready_i,
  input  logic [DW-1:0]     m_prdata_i,
  input  logic              m_pslverr_i
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rr;
  logic            r_gnt;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [2:0]      r_pprot;
  logic [SW-1:0]   r_pstrb;
  logic [DW-1:0]   r_pwdata;

  logic            w_req;
  logic            w_gnt;
  logic            w_cap;
  logic            w_done;
  logic            w_unused;

  // penable carries no information the arbiter needs.
  assign w_unused = ^s_penable_i;

  assign w_req  = |s_psel_i;
  // Requester 1 wins when alone, or when both ask and it holds priority.
  assign w_gnt  = s_psel_i[1] & (~s_psel_i[0] | r_rr);
  assign w_cap  = (r_state == IDLE) & w_req;
  assign w_done = (r_state == ACCESS) & m_pready_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (m_pready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) r_rr <= ~r_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gnt    <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pprot  <= '0;
      r_pstrb  <= '0;
      r_pwdata <= '0;
    end else if (w_cap) begin
      r_gnt    <= w_gnt;
      r_pwrite <= w_gnt ? s_pwrite_i[1] : s_pwrite_i[0];
      r_paddr  <= w_gnt ? s_paddr_i[2*AW-1:AW]
                        : s_paddr_i[AW-1:0];
      r_pprot  <= w_gnt ? s_pprot_i[5:3] : s_pprot_i[2:0];
      r_pstrb  <= w_gnt ? s_pstrb_i[2*SW-1:SW]
                        : s_pstrb_i[SW-1:0];
      r_pwdata <= w_gnt ? s_pwdata_i[2*DW-1:DW]
                        : s_pwdata_i[DW-1:0];
    end
  end

  // psel/penable decode straight from state so reset drops them at once.
  assign m_psel_o    = (r_state != IDLE);
  assign m_penable_o = (r_state == ACCESS);
  assign m_pwrite_o  = r_pwrite;
  assign m_paddr_o   = r_paddr;
  assign m_pprot_o   = r_pprot;
  assign m_pstrb_o   = r_pstrb;
  assign m_pwdata_o  = r_pwdata;

  assign s_pready_o  = {w_done & r_gnt, w_done & ~r_gnt};
  assign s_pslverr_o = {w_done & r_gnt & m_pslverr_i,
                        w_done & ~r_gnt & m_pslverr_i};
  assign s_prdata_o  = w_done ? m_prdata_i : '0;

endmodule

// File: tb/tb_apb4_arbiter2.sv
// Bench for apb4_arbiter2: vector table plus hand sequences, with a
// scoreboard of expected downstream transfers and upstream completions.
module tb_apb4_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          psel [2];
  logic          pen  [2];
  logic          pwr  [2];
  logic [AW-1:0] padr [2];
  logic [2:0]    pprt [2];
  logic [SW-1:0] pstb [2];
  logic [DW-1:0] pwd  [2];

  logic [1:0]      s_psel, s_pen, s_pwr;
  logic [2*AW-1:0] s_padr;
  logic [5:0]      s_pprt;
  logic [2*SW-1:0] s_pstb;
  logic [2*DW-1:0] s_pwd;
  assign s_psel = {psel[1], psel[0]};
  assign s_pen  = {pen[1], pen[0]};
  assign s_pwr  = {pwr[1], pwr[0]};
  assign s_padr = {padr[1], padr[0]};
  assign s_pprt = {pprt[1], pprt[0]};
  assign s_pstb = {pstb[1], pstb[0]};
  assign s_pwd  = {pwd[1], pwd[0]};

  logic [1:0]    s_pready_o, s_pslverr_o;
  logic [DW-1:0] s_prdata_o;
  logic          m_psel_o, m_penable_o, m_pwrite_o;
  logic [AW-1:0] m_paddr_o;
  logic [2:0]    m_pprot_o;
  logic [SW-1:0] m_pstrb_o;
  logic [DW-1:0] m_pwdata_o;
  logic          m_pready_i, m_pslverr_i;
  logic [DW-1:0] m_prdata_i;

  apb4_arbiter2 #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_psel_i(s_psel), .s_penable_i(s_pen),
    .s_pwrite_i(s_pwr), .s_paddr_i(s_padr),
    .s_pprot_i(s_pprt), .s_pstrb_i(s_pstb),
    .s_pwdata_i(s_pwd), .s_pready_o(s_pready_o),
    .s_prdata_o(s_prdata_o), .s_pslverr_o(s_pslverr_o),
    .m_psel_o(m_psel_o), .m_penable_o(m_penable_o),
    .m_pwrite_o(m_pwrite_o), .m_paddr_o(m_paddr_o),
    .m_pprot_o(m_pprot_o), .m_pstrb_o(m_pstrb_o),
    .m_pwdata_o(m_pwdata_o), .m_pready_i(m_pready_i),
    .m_prdata_i(m_prdata_i), .m_pslverr_i(m_pslverr_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    if (a == 32'hFFFF_0000) return 32'h101F_1010;
    if (a == 32'hFFFF_0008) return 32'hFFFF_FFFF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Downstream slave: dn_wait ACCESS wait states, then pready.
  int dn_wait = 0;
  bit dn_err = 1'b0;
  int wcnt;
  assign m_pready_i  = m_psel_o & m_penable_o & (wcnt == dn_wait);
  assign m_prdata_i  = m_pready_i ? rd_of(m_paddr_o) : '0;
  assign m_pslverr_i = m_pready_i & dn_err;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 0;
    else if (m_psel_o && m_penable_o && !m_pready_i) wcnt <= wcnt + 1;
    else wcnt <= 0;

  typedef struct {
    bit            rst;
    int            cnt0, cnt1;
    logic [AW-1:0] a0, a1;
    bit            w0, w1;
    logic [DW-1:0] d0, d1;
    logic [SW-1:0] s0, s1;
    logic [2:0]    p0, p1;
    int            waits;
    bit            err;
    int            first;
  } vec_t;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    bit            wr;
    logic [DW-1:0] wd;
    logic [SW-1:0] st;
    logic [2:0]    pr;
    bit            err;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t mkv(
    input bit rst, input int c0, input int c1,
    input logic [AW-1:0] a0, input logic [AW-1:0] a1,
    input bit w0, input bit w1,
    input logic [DW-1:0] d0, input logic [DW-1:0] d1,
    input logic [SW-1:0] s0, input logic [SW-1:0] s1,
    input logic [2:0] p0, input logic [2:0] p1,
    input int waits, input bit err, input int first);
    vec_t v;
    v.rst = rst; v.cnt0 = c0; v.cnt1 = c1;
    v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1;
    v.p0 = p0; v.p1 = p1; v.waits = waits;
    v.err = err; v.first = first;
    return v;
  endfunction

  function automatic exp_t mkexp(input int n, input vec_t v,
                                 input int j, input int c);
    exp_t e;
    e.id   = n;
    e.addr = (n == 0 ? v.a0 : v.a1) + AW'(4 * j);
    e.wr   = (n == 0) ? v.w0 : v.w1;
    e.wd   = (n == 0 ? v.d0 : v.d1) + DW'(j);
    e.st   = (n == 0) ? v.s0 : v.s1;
    e.pr   = (n == 0) ? v.p0 : v.p1;
    e.err  = v.err;
    e.cyc  = c;
    return e;
  endfunction

  task automatic drive(input int n, input vec_t v, input int j);
    psel[n] = 1'b1;
    pen[n]  = 1'b0;
    padr[n] = (n == 0 ? v.a0 : v.a1) + AW'(4 * j);
    pwr[n]  = (n == 0) ? v.w0 : v.w1;
    pwd[n]  = (n == 0 ? v.d0 : v.d1) + DW'(j);
    pstb[n] = (n == 0) ? v.s0 : v.s1;
    pprt[n] = (n == 0) ? v.p0 : v.p1;
  endtask

  task automatic idle_all();
    for (int n = 0; n < 2; n++) begin
      psel[n] = 1'b0; pen[n] = 1'b0; pwr[n] = 1'b0;
      padr[n] = '0; pprt[n] = '0; pstb[n] = '0; pwd[n] = '0;
    end
  endtask

  int tb_rr = 0;

  task automatic reset_dut(input int n);
    idle_all();
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    tb_rr = 0;
  endtask

  // Monitor: stability across ACCESS, scoreboard at completion.
  logic [AW-1:0] sn_addr;
  logic [DW-1:0] sn_wd;
  logic [SW-1:0] sn_st;
  logic [2:0]    sn_pr;
  logic          sn_wr;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m_psel_o && !m_penable_o) begin
        sn_addr = m_paddr_o; sn_wd = m_pwdata_o;
        sn_st = m_pstrb_o; sn_pr = m_pprot_o; sn_wr = m_pwrite_o;
      end
      if (m_psel_o && m_penable_o)
        chk("access_stable",
            64'({m_paddr_o, m_pwrite_o, m_pprot_o, m_pstrb_o}),
            64'({sn_addr, sn_wr, sn_pr, sn_st}));
      if (m_psel_o && m_penable_o && m_pready_i) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 64'(s_pready_o), 64'(0));
          chk("sb_nonempty", 64'(0), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("sb_paddr", 64'(m_paddr_o), 64'(e.addr));
          chk("sb_pwrite", 64'(m_pwrite_o), 64'(e.wr));
          chk("sb_pwdata", 64'(m_pwdata_o), 64'(e.wd));
          chk("sb_pstrb", 64'(m_pstrb_o), 64'(e.st));
          chk("sb_pprot", 64'(m_pprot_o), 64'(e.pr));
          chk("sb_pready", 64'(s_pready_o),
              64'(e.id == 1 ? 2'b10 : 2'b01));
          chk("sb_pslverr", 64'(s_pslverr_o),
              64'(!e.err ? 2'b00 : (e.id == 1 ? 2'b10 : 2'b01)));
          chk("sb_prdata", 64'(s_prdata_o), 64'(rd_of(e.addr)));
          chk("sb_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("idle_pready", 64'({s_pready_o, s_pslverr_o}), 64'(0));
        chk("idle_prdata", 64'(s_prdata_o), 64'(0));
      end
    end
  end

  task automatic run_vec(input vec_t v, input string nm);
    int r[2];
    int jj[2];
    bit cmp[2];
    int k, pk, t0, budget, first_seen;
    if (v.rst) reset_dut(3);
    dn_wait = v.waits;
    dn_err  = v.err;
    @(posedge clk);
    #1 t0 = cyc;
    r[0] = v.cnt0; r[1] = v.cnt1; jj[0] = 0; jj[1] = 0; k = 0;
    while (r[0] + r[1] > 0) begin
      if (r[0] > 0 && r[1] > 0) pk = tb_rr;
      else pk = (r[1] > 0) ? 1 : 0;
      sb.push_back(mkexp(pk, v, jj[pk],
                         t0 + 2 + v.waits + k * (3 + v.waits)));
      jj[pk]++; r[pk]--; k++;
      tb_rr = (pk == 0) ? 1 : 0;
    end
    r[0] = v.cnt0; r[1] = v.cnt1; jj[0] = 0; jj[1] = 0;
    cmp[0] = 1'b0; cmp[1] = 1'b0;
    for (int n = 0; n < 2; n++) if (r[n] > 0) drive(n, v, 0);
    first_seen = -1;
    budget = (v.cnt0 + v.cnt1) * (3 + v.waits) + 10;
    while (r[0] + r[1] > 0 && budget > 0) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++)
        if (psel[n] && s_pready_o[n]) begin
          cmp[n] = 1'b1;
          if (first_seen < 0) first_seen = n;
        end
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (cmp[n]) begin
          cmp[n] = 1'b0; r[n]--; jj[n]++;
          if (r[n] > 0) drive(n, v, jj[n]);
          else begin psel[n] = 1'b0; pen[n] = 1'b0; end
        end else if (psel[n]) pen[n] = 1'b1;
      end
      budget--;
    end
    if (budget == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got budget expired want all done", nm);
      idle_all();
    end
    chk({nm, "_first"}, 64'(first_seen), 64'(v.first));
    chk({nm, "_sb_drained"}, 64'(sb.size()), 64'(0));
  endtask

  vec_t vt[6];
  vec_t vb;

  initial begin
    int t0, budget;
    idle_all();
    reset_dut(40);
    #1;
    chk("rst_m_ctl", 64'({m_psel_o, m_penable_o, m_pwrite_o}), 64'(0));
    chk("rst_m_paddr", 64'(m_paddr_o), 64'(0));
    chk("rst_m_data",
        64'({m_pprot_o, m_pstrb_o, m_pwdata_o}), 64'(0));
    chk("rst_s_resp", 64'({s_pready_o, s_pslverr_o}), 64'(0));
    chk("rst_s_prdata", 64'(s_prdata_o), 64'(0));

    vt[0] = mkv(0, 1, 0, 32'hFFFF_0000, 32'h0, 0, 0, 32'h0, 32'h0,
                4'hF, 4'hF, 3'd0, 3'd0, 0, 0, 0);
    vt[1] = mkv(1, 1, 1, 32'hFFFF_0004, 32'hFFFF_0008, 0, 0,
                32'h0, 32'h0, 4'hF, 4'hF, 3'd0, 3'd0, 0, 0, 0);
    vt[2] = mkv(0, 4, 4, 32'h100, 32'h200, 1, 0,
                32'h1111_0000, 32'h2222_0000, 4'hF, 4'hF,
                3'b001, 3'b010, 0, 0, 0);
    vt[3] = mkv(0, 0, 1, 32'h0, 32'h0C, 0, 1, 32'h0, 32'hA5A5_5A5A,
                4'hF, 4'b0011, 3'd0, 3'd0, 5, 1, 1);
    vt[4] = mkv(0, 1, 1, 32'h300, 32'h304, 1, 1,
                32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b1000, 4'b0101,
                3'b111, 3'b100, 1, 0, 0);
    vt[5] = mkv(0, 2, 1, 32'h400, 32'h500, 0, 1,
                32'h0, 32'h1234_5678, 4'hF, 4'hF,
                3'd0, 3'b011, 0, 1, 0);
    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset while ACCESS is waiting on the slave.
    dn_wait = 3; dn_err = 1'b0;
    @(posedge clk);
    #1;
    vb = mkv(0, 0, 1, 32'h0, 32'h20, 0, 0, 32'h0, 32'h0,
             4'hF, 4'hF, 3'd0, 3'd0, 3, 0, 1);
    drive(1, vb, 0);
    @(posedge clk);
    #1 pen[1] = 1'b1;
    chk("rstA_setup", 64'({m_psel_o, m_penable_o}), 64'(2'b10));
    @(posedge clk);
    #1;
    chk("rstA_access", 64'({m_psel_o, m_penable_o}), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("rstA_mpsel", 64'({m_psel_o, m_penable_o}), 64'(0));
    chk("rstA_spready", 64'(s_pready_o), 64'(0));
    chk("rstA_mpaddr", 64'(m_paddr_o), 64'(0));
    idle_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tb_rr = 0;
    vb = mkv(0, 0, 1, 32'h0, 32'h24, 0, 0, 32'h0, 32'h0,
             4'hF, 4'hF, 3'd0, 3'd0, 0, 0, 1);
    run_vec(vb, "post_rst");

    // Requester 0 drops psel in SETUP; pending requester 1 follows.
    dn_wait = 0; dn_err = 1'b0;
    vb = mkv(0, 1, 1, 32'h40, 32'h80, 0, 1, 32'h0, 32'h7777_0001,
             4'hF, 4'hC, 3'b010, 3'b001, 0, 0, 0);
    @(posedge clk);
    #1 t0 = cyc;
    sb.push_back(mkexp(0, vb, 0, t0 + 2));
    sb.push_back(mkexp(1, vb, 0, t0 + 5));
    drive(0, vb, 0);
    @(posedge clk);
    #1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    drive(1, vb, 0);
    budget = 12;
    while (budget > 0) begin
      @(negedge clk);
      if (s_pready_o[1]) break;
      @(posedge clk);
      #1 pen[1] = 1'b1;
      budget--;
    end
    if (budget == 0) begin
      n_chk++; n_fail++;
      $display("FAIL drop_timeout: got no pready[1] want pready[1]");
    end
    @(posedge clk);
    #1 idle_all();
    tb_rr = 0;
    chk("drop_sb_drained", 64'(sb.size()), 64'(0));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

endmodule
